// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 refresh controller.
// The optional refresh_req / IDLE feature is selected by macro LCD_REFRESH_REQ_EN.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   // Write indices: INIT uses 0..3; a frame uses 0..33, where 0 and 17 are line addresses.
   localparam logic [5:0] INIT_LEN  = 6'd4;
   localparam logic [5:0] FRAME_LEN = 6'd34;
   localparam logic [5:0] LINE2_IDX = 6'd17;
   localparam int         SETUP_CYC = 2;

   typedef enum logic [1:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_FRAME
`ifdef LCD_REFRESH_REQ_EN
      , ST_IDLE
`endif
   } ctrl_state_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD
   } wr_phase_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_ON;
         2'd2:    return CMD_CLEAR;
         default: return CMD_ENTRY;
      endcase
   endfunction

   // Width of the shared wait counter: must hold the longer of the two long waits.
   function automatic int cnt_width(input int pwr_cyc, input int clr_cyc);
      int m;
      m = (pwr_cyc > clr_cyc) ? pwr_cyc : clr_cyc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One HD44780 bus write: SETUP (2 cycles) -> STROBE (EN_CYC, EN high) -> HOLD.
// HOLD lasts CLR_CYC after a clear command (RS=0, 0x01), otherwise CMD_CYC.
module lcd_bus_writer
   import lcd_pkg::*;
#(
   parameter int EN_CYC  = 25,
   parameter int CMD_CYC = 2500,
   parameter int CLR_CYC = 100000,
   parameter int CW      = 17
) (
   input  logic          clk,
   input  logic          reset,
   // Handshake: start is sampled only while the writer is idle or while done is high,
   // so a new write can follow the previous HOLD with no gap. wdata/wrs are captured
   // on the start edge. done is high for exactly the last HOLD cycle of each write.
   input  logic          start,
   input  logic [7:0]    wdata,
   input  logic          wrs,
   input  logic          cnt_zero,
   output logic          cnt_load,
   output logic [CW-1:0] cnt_val,
   output logic          done,
   output logic [7:0]    data,
   output logic          rs,
   output logic          en
);

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
   localparam logic [CW-1:0] CMD_LD   = CW'(CMD_CYC - 1);
   localparam logic [CW-1:0] CLR_LD   = CW'(CLR_CYC - 1);

   wr_phase_t phase, phase_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= WR_IDLE;
         data  <= 8'h00;
         rs    <= 1'b0;
         en    <= 1'b0;
      end else begin
         phase <= phase_d;
         en    <= (phase_d == WR_STROBE);
         if (start) begin
            data <= wdata;
            rs   <= wrs;
         end
      end
   end

   always_comb begin
      phase_d  = phase;
      cnt_load = 1'b0;
      cnt_val  = '0;
      done     = 1'b0;
      case (phase)
         WR_SETUP: if (cnt_zero) begin
            phase_d  = WR_STROBE;
            cnt_load = 1'b1;
            cnt_val  = EN_LD;
         end
         WR_STROBE: if (cnt_zero) begin
            phase_d  = WR_HOLD;
            cnt_load = 1'b1;
            cnt_val  = (!rs && data == CMD_CLEAR) ? CLR_LD : CMD_LD;
         end
         WR_HOLD: if (cnt_zero) begin
            done    = 1'b1;
            phase_d = WR_IDLE;
         end
         default: ;
      endcase
      if (start) begin
         phase_d  = WR_SETUP;
         cnt_load = 1'b1;
         cnt_val  = SETUP_LD;
      end
   end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 refresh controller: power-up wait, init commands, then continuous frames
// from a 32-byte character RAM. Macro LCD_REFRESH_REQ_EN adds refresh_req and an IDLE state.
module lcd_refresh_ctrl
   import lcd_pkg::*;
#(
   parameter int EN_CYC  = 25,
   parameter int CMD_CYC = 2500,
   parameter int CLR_CYC = 100000,
   parameter int PWR_CYC = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   output logic [4:0] raddr,
   input  logic [7:0] rdata,
`ifdef LCD_REFRESH_REQ_EN
   input  logic       refresh_req,
`endif
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_ON,
   output logic       LCD_BLON,
   output logic       ready
);

   localparam int            CW     = cnt_width(PWR_CYC, CLR_CYC);
   localparam logic [CW-1:0] PWR_LD = CW'(PWR_CYC - 1);

   ctrl_state_t   state, state_d;
   logic [5:0]    idx, idx_d, fr_idx;
   logic [4:0]    raddr_d;
   logic          ready_d;
   logic [CW-1:0] wait_cnt, cnt_val;
   logic          cnt_zero, cnt_load;
   logic          start, wrs, done, fr_rs;
   logic [7:0]    wdata, fr_data;

   assign LCD_RW   = 1'b0;
   assign LCD_ON   = 1'b1;
   assign LCD_BLON = 1'b1;
   assign cnt_zero = (wait_cnt == '0);

   // One down-counter times the power-up wait and every write phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_PWR_WAIT;
         idx      <= 6'd0;
         raddr    <= 5'd0;
         ready    <= 1'b0;
         wait_cnt <= PWR_LD;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         raddr <= raddr_d;
         ready <= ready_d;
         if (cnt_load)
            wait_cnt <= cnt_val;
         else if (!cnt_zero)
            wait_cnt <= wait_cnt - CW'(1);
      end
   end

   always_comb begin
      state_d = state;
      idx_d   = idx;
      raddr_d = raddr;
      ready_d = ready;
      start   = 1'b0;
      wdata   = 8'h00;
      wrs     = 1'b0;

      // Next frame write; any entry into a new frame starts at index 0 (line-1 address).
      fr_idx = (state == ST_FRAME && idx != FRAME_LEN) ? idx : 6'd0;
      if (fr_idx == 6'd0) begin
         fr_data = CMD_LINE1;
         fr_rs   = 1'b0;
      end else if (fr_idx == LINE2_IDX) begin
         fr_data = CMD_LINE2;
         fr_rs   = 1'b0;
      end else begin
         fr_data = rdata;
         fr_rs   = 1'b1;
      end

      case (state)
         ST_PWR_WAIT: if (cnt_zero) begin
            start   = 1'b1;
            wdata   = init_cmd(2'd0);
            idx_d   = 6'd1;
            state_d = ST_INIT;
         end
         ST_INIT: if (done) begin
            if (idx == INIT_LEN) begin
               ready_d = 1'b1;
`ifdef LCD_REFRESH_REQ_EN
               state_d = ST_IDLE;
`else
               state_d = ST_FRAME;
               start   = 1'b1;
               wdata   = fr_data;
               wrs     = fr_rs;
               idx_d   = fr_idx + 6'd1;
`endif
            end else begin
               start = 1'b1;
               wdata = init_cmd(idx[1:0]);
               idx_d = idx + 6'd1;
            end
         end
         ST_FRAME: if (done) begin
`ifdef LCD_REFRESH_REQ_EN
            if (idx == FRAME_LEN) begin
               state_d = ST_IDLE;
            end else begin
`else
            begin
`endif
               start = 1'b1;
               wdata = fr_data;
               wrs   = fr_rs;
               idx_d = fr_idx + 6'd1;
               // raddr always points at the next character to be captured.
               if (fr_rs)
                  raddr_d = raddr + 5'd1;
            end
         end
`ifdef LCD_REFRESH_REQ_EN
         ST_IDLE: if (refresh_req) begin
            state_d = ST_FRAME;
            start   = 1'b1;
            wdata   = fr_data;
            wrs     = fr_rs;
            idx_d   = fr_idx + 6'd1;
         end
`endif
         default: state_d = ST_PWR_WAIT;
      endcase
   end

   lcd_bus_writer #(
      .EN_CYC  (EN_CYC),
      .CMD_CYC (CMD_CYC),
      .CLR_CYC (CLR_CYC),
      .CW      (CW)
   ) u_writer (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .wdata    (wdata),
      .wrs      (wrs),
      .cnt_zero (cnt_zero),
      .cnt_load (cnt_load),
      .cnt_val  (cnt_val),
      .done     (done),
      .data     (LCD_DATA),
      .rs       (LCD_RS),
      .en       (LCD_EN)
   );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl with short timing parameters; every observed bus write is
// compared against a queue of expected {RS, DATA} values. Handles LCD_REFRESH_REQ_EN builds.
module tb_lcd_refresh_ctrl;

   localparam int EN_CYC    = 2;
   localparam int CMD_CYC   = 4;
   localparam int CLR_CYC   = 8;
   localparam int PWR_CYC   = 10;
   localparam int BANG_ADDR = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] raddr;
   logic [7:0] rdata;
   logic [7:0] LCD_DATA;
   logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, ready;
`ifdef LCD_REFRESH_REQ_EN
   logic       refresh_req = 1'b0;
`endif

   logic [7:0] ram [32];
   assign rdata = ram[raddr];

   always #5 clk = ~clk;

   lcd_refresh_ctrl #(
      .EN_CYC  (EN_CYC),
      .CMD_CYC (CMD_CYC),
      .CLR_CYC (CLR_CYC),
      .PWR_CYC (PWR_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .raddr       (raddr),
      .rdata       (rdata),
`ifdef LCD_REFRESH_REQ_EN
      .refresh_req (refresh_req),
`endif
      .LCD_DATA    (LCD_DATA),
      .LCD_RS      (LCD_RS),
      .LCD_RW      (LCD_RW),
      .LCD_EN      (LCD_EN),
      .LCD_ON      (LCD_ON),
      .LCD_BLON    (LCD_BLON),
      .ready       (ready)
   );

   typedef struct {
      logic       use_ram;
      logic [4:0] addr;
      logic [7:0] ch;
      logic [8:0] exp;
   } vec_t;

   vec_t       vecs [34];
   logic [8:0] init_exp [4];
   logic [8:0] exp_q [$];
   logic [8:0] mon_e;
   logic       en_prev = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         wr_cnt = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   function automatic logic [7:0] char_at(input string str, input int col);
      return (col < str.len()) ? str[col] : 8'h20;
   endfunction

   task automatic wait_strobe(input string name, input logic [7:0] d, input int limit);
      int n = 0;
      while (!(LCD_EN === 1'b1 && LCD_DATA === d) && n < limit) begin
         @(posedge clk); #2; n++;
      end
      check(name, 32'(LCD_EN === 1'b1 && LCD_DATA === d), 32'd1);
   endtask

   task automatic wait_en_low(input int limit);
      int n = 0;
      while (LCD_EN !== 1'b0 && n < limit) begin
         @(posedge clk); #2; n++;
      end
   endtask

   task automatic count_data(input logic [7:0] d, input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk); #2; n++;
      end while (LCD_DATA !== d && n < limit);
   endtask

   task automatic count_ready(input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk); #2; n++;
      end while (ready !== 1'b1 && n < limit);
   endtask

   task automatic count_en(input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk); #2; n++;
      end while (LCD_EN !== 1'b1 && n < limit);
   endtask

`ifdef LCD_REFRESH_REQ_EN
   task automatic refresh_frame(input string name);
      int n_en = 0;
      wait_en_low(20);
      repeat (CMD_CYC) begin
         @(posedge clk); #2;
      end
      repeat (20) begin
         @(posedge clk); #2;
         if (LCD_EN === 1'b1) n_en++;
      end
      check({name, "_idle_no_en"}, 32'(n_en), 32'd0);
      refresh_req = 1'b1;
      @(posedge clk); #2;
      refresh_req = 1'b0;
      check({name, "_setup_line1"}, 32'(LCD_DATA), 32'h80);
   endtask
`endif

   initial begin
      int n;
      string l1, l2;
      logic [8:0] e;

      init_exp = '{9'h038, 9'h00C, 9'h001, 9'h006};
      l1 = "Hello";
      l2 = "World";
      for (int s = 0; s < 34; s++) begin
         if (s == 0) begin
            vecs[s] = '{1'b0, 5'd0, 8'h00, 9'h080};
         end else if (s == 17) begin
            vecs[s] = '{1'b0, 5'd0, 8'h00, 9'h0C0};
         end else begin
            vecs[s].use_ram = 1'b1;
            vecs[s].addr    = (s < 17) ? 5'(s - 1) : 5'(s - 2);
            vecs[s].ch      = (s < 17) ? char_at(l1, s - 1) : char_at(l2, s - 18);
            vecs[s].exp     = {1'b1, vecs[s].ch};
         end
      end
      for (int s = 0; s < 34; s++)
         if (vecs[s].use_ram) ram[vecs[s].addr] = vecs[s].ch;

      // Write monitor: each LCD_EN rise consumes the next expected write.
      fork
         forever begin
            @(posedge clk); #1;
            if (LCD_EN === 1'b1 && en_prev !== 1'b1) begin
               wr_cnt++;
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  check($sformatf("write%0d", wr_cnt), {23'd0, LCD_RS, LCD_DATA}, {23'd0, mon_e});
               end
            end
            en_prev = LCD_EN;
         end
      join_none

      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_raddr", 32'(raddr), 32'd0);
      check("rst_data", 32'(LCD_DATA), 32'h00);
      check("rst_rs", 32'(LCD_RS), 32'd0);
      check("rst_rw", 32'(LCD_RW), 32'd0);
      check("rst_en", 32'(LCD_EN), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_on", 32'(LCD_ON), 32'd1);
      check("rst_blon", 32'(LCD_BLON), 32'd1);

      foreach (init_exp[i]) exp_q.push_back(init_exp[i]);
      for (int s = 0; s < 34; s++) exp_q.push_back(vecs[s].exp);
      wr_cnt = 0;
      reset = 1'b0;

      // Power-up wait then 2-cycle SETUP
      count_en(60, n);
      check("pwr_en_rise", 32'(n), 32'd12);
      check("pwr_data", 32'(LCD_DATA), 32'h38);
      check("pwr_rs", 32'(LCD_RS), 32'd0);

      // Clear command gets the long HOLD
      wait_strobe("clr_strobe", 8'h01, 200);
      wait_en_low(50);
      count_data(8'h06, 50, n);
      check("clr_gap", 32'(n), 32'd8);
      check("ready_low_in_init", 32'(ready), 32'd0);

      wait_strobe("entry_strobe", 8'h06, 50);
      wait_en_low(50);
      count_ready(50, n);
      check("ready_rise", 32'(n), 32'd4);
`ifdef LCD_REFRESH_REQ_EN
      refresh_frame("first_frame");
`else
      check("frame_after_init", 32'(LCD_DATA), 32'h80);
`endif

      // Overwrite a character just after its capture in frame 1
      n = 0;
      while (wr_cnt < 4 + BANG_ADDR + 2 && n < 1000) begin
         @(posedge clk); #2; n++;
      end
      check("bang_slot_seen", 32'(wr_cnt), 32'(4 + BANG_ADDR + 2));
      ram[BANG_ADDR] = 8'h21;
      for (int s = 0; s < 34; s++) begin
         e = vecs[s].exp;
         if (s == BANG_ADDR + 1) e = {1'b1, 8'h21};
         exp_q.push_back(e);
      end

      // Frame-to-frame turnaround after the last character
      n = 0;
      while (wr_cnt < 4 + 34 && n < 1000) begin
         @(posedge clk); #2; n++;
      end
      check("frame1_last_seen", 32'(wr_cnt), 32'd38);
      wait_en_low(20);
`ifdef LCD_REFRESH_REQ_EN
      refresh_frame("second_frame");
`else
      count_data(8'h80, 20, n);
      check("frame_turnaround", 32'(n), 32'd4);
`endif

      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk); #2; n++;
      end
      check("frame2_drained", 32'(exp_q.size()), 32'd0);
      check("ready_held", 32'(ready), 32'd1);
      check("rw_low", 32'(LCD_RW), 32'd0);

      // Reset in the middle of a strobe
`ifdef LCD_REFRESH_REQ_EN
      refresh_frame("third_frame");
`endif
      n = 0;
      while (LCD_EN !== 1'b1 && n < 200) begin
         @(posedge clk); #2; n++;
      end
      check("strobe_found", 32'(LCD_EN), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_en", 32'(LCD_EN), 32'd0);
      check("mid_rst_ready", 32'(ready), 32'd0);
      check("mid_rst_raddr", 32'(raddr), 32'd0);
      check("mid_rst_data", 32'(LCD_DATA), 32'h00);
      foreach (init_exp[i]) exp_q.push_back(init_exp[i]);
      reset = 1'b0;
      count_en(60, n);
      check("mid_rst_en_rise", 32'(n), 32'd12);
      check("mid_rst_first_data", 32'(LCD_DATA), 32'h38);
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #2; n++;
      end
      check("reinit_drained", 32'(exp_q.size()), 32'd0);
      count_ready(50, n);
      check("reinit_ready", 32'(ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
